ori_hist32: RTL and testbench
=============================

# ori_hist32

Orientation-histogram accumulator for the keypoint orientation-assignment stage. It consumes the stream of 5-bit direction bins produced by the direction lookup ROMs, each paired with a gradient magnitude. It accumulates a 32-bin magnitude-weighted histogram per keypoint window. After the window's last sample it scans the bins and reports the dominant bin and its weight to the descriptor stage.

## Interface
Parameters:
- MAG_W, 8, width of the gradient magnitude input
- ACC_W, 16, width of each histogram accumulator and of peak_val

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- din_valid  input  1  sample present
- din_ready  output  1  block accepts a sample this cycle
- din_dir  input  5  direction bin 0..31
- din_mag  input  MAG_W  gradient magnitude, unsigned
- din_last  input  1  marks the final sample of the keypoint window
- peak_valid  output  1  peak result valid
- peak_ready  input  1  downstream accepts the result
- peak_bin  output  5  index of the dominant bin
- peak_val  output  ACC_W  accumulated weight of the dominant bin
- busy  output  1  high in SCAN or DONE

## Operation
- The block holds 32 registered accumulators, hist[0..31], each ACC_W bits and unsigned.
- The FSM has three states: ACCUM, SCAN and DONE.
- ACCUM:
  - din_ready=1.
  - A sample is accepted when din_valid and din_ready are both high. On acceptance, hist[din_dir] <= sat(hist[din_dir] + din_mag).
  - sat() clamps the sum to 2^ACC_W-1 when it would overflow. There is no wrap-around.
  - din_mag is zero-extended to ACC_W bits.
  - Accepting a sample with din_last=1 performs that sample's update and moves to SCAN.
- SCAN:
  - din_ready=0.
  - A 5-bit index k runs 0..31, one bin per cycle.
  - A running best (best_bin, best_val) starts at bin 0 / value 0. It is replaced only when hist[k] > best_val (strict), so the lowest index wins ties.
  - After k=31 the FSM moves to DONE. peak_bin/peak_val are loaded from the running best.
- DONE:
  - peak_valid=1. peak_bin and peak_val are held stable.
  - din_ready=0.
  - On peak_valid && peak_ready, all 32 accumulators clear to 0 and the FSM returns to ACCUM.
- peak_valid is never dropped without a handshake.
- busy = (state != ACCUM).
- A window in which every magnitude is 0, or whose only sample is the din_last one with zero magnitude, reports peak_bin=0 and peak_val=0.
- din_dir and din_mag are ignored unless a sample is accepted.

## Timing
- Reset (synchronous, rst high at a rising edge):
  - state=ACCUM, all hist=0, k=0.
  - peak_valid=0, peak_bin=0, peak_val=0, busy=0, din_ready=1.
- rst dominates every other input, including mid-SCAN and in DONE. Any partial histogram is discarded.
- Throughput in ACCUM is one sample per cycle. A back-to-back update of the same bin must accumulate correctly with no stall; use a write-first update on the registered value.
- Let the last sample be accepted at edge T:
  - edge T: state=SCAN.
  - edges T+1..T+32: bins 0..31 examined (bin k at edge T+1+k). The bin-0 examination sees hist values that include the last sample.
  - edge T+32: state=DONE. peak_valid=1 is first observed in the cycle after T+32.
  - Latency from last accept to peak_valid is 32 cycles.
- DONE → ACCUM at the edge where peak_ready=1 is sampled with peak_valid=1. In the next cycle peak_valid=0, din_ready=1 and hist are all 0.
- Minimum window period is N samples + 32 scan cycles + 1 handshake cycle.
- peak_bin and peak_val keep their last value after the handshake. They are meaningful only while peak_valid=1.

## Test plan
- Reset check: assert rst for 2 cycles during a SCAN → next cycle din_ready=1, peak_valid=0, busy=0. A following window with a single sample (dir=7, mag=5, last) → peak_bin=7, peak_val=5.
- Single-bin accumulation: 4 back-to-back samples, dir=3, mag=10,20,30,40, the last with din_last=1 → peak_valid exactly 32 cycles after the last accept, peak_bin=3, peak_val=100.
- Tie-break: dir=20 mag=50, then dir=4 mag=50 (last) → peak_bin=4, peak_val=50. Swapping the sample order gives the same result.
- Saturation: with ACC_W=16 and MAG_W=8, 300 samples of dir=31, mag=255 (last on #300) → peak_val=16'hFFFF, peak_bin=31. No wrap occurs.
- Backpressure and clear:
  - Hold peak_ready=0 for 10 cycles in DONE → peak_valid, peak_bin and peak_val stay constant and din_ready=0.
  - Then pulse peak_ready → the next window, a single sample (dir=0, mag=1, last), reports peak_bin=0 and peak_val=1. This proves the histogram was cleared.
- All-zero window: 16 samples with mag=0 on varied dirs → peak_bin=0, peak_val=0.

Source files
------------

// File: rtl/ori_hist32.sv
// Orientation-histogram accumulator: builds a 32-bin magnitude-weighted histogram
// per keypoint window, then scans it for the dominant bin (lowest index wins ties).
module ori_hist32 #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [4:0]       din_dir,
  input  logic [MAG_W-1:0] din_mag,
  input  logic             din_last,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [4:0]       peak_bin,
  output logic [ACC_W-1:0] peak_val,
  output logic             busy
);

  typedef enum logic [1:0] {ST_ACCUM, ST_SCAN, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_hist [32];
  logic [4:0]       r_k;
  logic [4:0]       r_best_bin;
  logic [ACC_W-1:0] r_best_val;
  logic [4:0]       r_peak_bin;
  logic [ACC_W-1:0] r_peak_val;

  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_sat;
  logic [ACC_W-1:0] w_scan_val;
  logic             w_better;

  assign w_accept = din_valid && (r_state == ST_ACCUM);

  // One extra bit catches the carry; the addend is the current registered bin,
  // so back-to-back hits on the same bin chain through without a stall.
  assign w_sum = {1'b0, r_hist[din_dir]} + {{(ACC_W + 1 - MAG_W){1'b0}}, din_mag};
  assign w_sat = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  assign w_scan_val = r_hist[r_k];
  assign w_better   = (w_scan_val > r_best_val);

  always_comb begin
    w_state_next = r_state;
    din_ready    = 1'b0;
    peak_valid   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_ACCUM: begin
        din_ready = 1'b1;
        busy      = 1'b0;
        if (din_valid && din_last) w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (r_k == 5'd31) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        peak_valid = 1'b1;
        if (peak_ready) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_hist[i] <= '0;
      r_k        <= '0;
      r_best_bin <= '0;
      r_best_val <= '0;
      r_peak_bin <= '0;
      r_peak_val <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_hist[din_dir] <= w_sat;
            if (din_last) begin
              r_k        <= '0;
              r_best_bin <= '0;
              r_best_val <= '0;
            end
          end
        end
        ST_SCAN: begin
          if (w_better) begin
            r_best_bin <= r_k;
            r_best_val <= w_scan_val;
          end
          r_k <= r_k + 5'd1;
          // Final bin is folded in directly so the result is ready on entry to DONE.
          if (r_k == 5'd31) begin
            r_peak_bin <= w_better ? r_k : r_best_bin;
            r_peak_val <= w_better ? w_scan_val : r_best_val;
          end
        end
        ST_DONE: begin
          if (peak_ready) begin
            for (int i = 0; i < 32; i++) r_hist[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign peak_bin = r_peak_bin;
  assign peak_val = r_peak_val;

endmodule

// File: tb/tb_ori_hist32.sv
// Self-checking bench for ori_hist32: table vectors, directed corner sequences
// and random windows scored against a plain-arithmetic histogram model.
module tb_ori_hist32;

  localparam int MAG_W = 8;
  localparam int ACC_W = 16;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             din_valid;
  logic             din_ready;
  logic [4:0]       din_dir;
  logic [MAG_W-1:0] din_mag;
  logic             din_last;
  logic             peak_valid;
  logic             peak_ready;
  logic [4:0]       peak_bin;
  logic [ACC_W-1:0] peak_val;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  int q_dir[$];
  int q_mag[$];

  typedef struct {
    int n;
    int d[4];
    int m[4];
    int exp_bin;
    int exp_val;
  } vec_t;

  vec_t vecs[6];

  ori_hist32 #(.MAG_W(MAG_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_dir(din_dir), .din_mag(din_mag), .din_last(din_last),
    .peak_valid(peak_valid), .peak_ready(peak_ready),
    .peak_bin(peak_bin), .peak_val(peak_val), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: saturating per-bin sums, then first index holding the maximum.
  task automatic model(output int bin, output int val);
    int h[32];
    for (int i = 0; i < 32; i++) h[i] = 0;
    for (int i = 0; i < q_dir.size(); i++) begin
      h[q_dir[i]] += q_mag[i];
      if (h[q_dir[i]] > ACC_MAX) h[q_dir[i]] = ACC_MAX;
    end
    bin = 0;
    val = h[0];
    for (int i = 1; i < 32; i++)
      if (h[i] > val) begin
        bin = i;
        val = h[i];
      end
  endtask

  // Drive queued samples; optional idle gaps carry garbage that must be ignored.
  task automatic drive_samples(input bit gaps);
    for (int i = 0; i < q_dir.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          din_valid = 1'b0;
          din_dir   = 5'($urandom);
          din_mag   = 8'($urandom);
          din_last  = 1'($urandom);
        end
      end
      @(negedge clk);
      if (!din_ready) begin
        n_checks++;
        n_errors++;
        $display("FAIL ready_in_accum: got 0 expected 1");
      end
      din_valid = 1'b1;
      din_dir   = 5'(q_dir[i]);
      din_mag   = 8'(q_mag[i]);
      din_last  = (i == q_dir.size() - 1);
    end
    @(negedge clk);
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  // Called at the negedge right after the last accept.
  task automatic finish_window(input string name, input int exp_bin, input int exp_val,
                               input int hold);
    int lat;
    int b0;
    int v0;
    check({name, "_busy_scan"}, int'(busy), 1);
    check({name, "_ready_scan"}, int'(din_ready), 0);
    lat = 0;
    while (!peak_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 32);
    check({name, "_bin"}, int'(peak_bin), exp_bin);
    check({name, "_val"}, int'(peak_val), exp_val);
    $display("window %s: n=%0d bin=%0d val=%0d latency=%0d", name, q_dir.size(),
             peak_bin, peak_val, lat);
    b0 = int'(peak_bin);
    v0 = int'(peak_val);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, int'(peak_valid), 1);
      check({name, "_hold_bin"}, int'(peak_bin), b0);
      check({name, "_hold_val"}, int'(peak_val), v0);
      check({name, "_hold_ready"}, int'(din_ready), 0);
    end
    peak_ready = 1'b1;
    @(negedge clk);
    peak_ready = 1'b0;
    check({name, "_post_valid"}, int'(peak_valid), 0);
    check({name, "_post_ready"}, int'(din_ready), 1);
    check({name, "_post_busy"}, int'(busy), 0);
  endtask

  task automatic run_queue(input string name, input bit gaps, input int hold);
    int eb;
    int ev;
    model(eb, ev);
    drive_samples(gaps);
    finish_window(name, eb, ev, hold);
  endtask

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_dir    = '0;
    din_mag    = '0;
    din_last   = 1'b0;
    peak_ready = 1'b0;

    vecs[0] = '{n: 1, d: '{7, 0, 0, 0},   m: '{5, 0, 0, 0},     exp_bin: 7,  exp_val: 5};
    vecs[1] = '{n: 4, d: '{3, 3, 3, 3},   m: '{10, 20, 30, 40}, exp_bin: 3,  exp_val: 100};
    vecs[2] = '{n: 2, d: '{20, 4, 0, 0},  m: '{50, 50, 0, 0},   exp_bin: 4,  exp_val: 50};
    vecs[3] = '{n: 2, d: '{4, 20, 0, 0},  m: '{50, 50, 0, 0},   exp_bin: 4,  exp_val: 50};
    vecs[4] = '{n: 1, d: '{9, 0, 0, 0},   m: '{0, 0, 0, 0},     exp_bin: 0,  exp_val: 0};
    vecs[5] = '{n: 3, d: '{31, 30, 31, 0}, m: '{7, 9, 3, 0},    exp_bin: 31, exp_val: 10};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", int'(din_ready), 1);
    check("rst_valid", int'(peak_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bin", int'(peak_bin), 0);
    check("rst_val", int'(peak_val), 0);

    // Reset in the middle of SCAN discards the partial histogram.
    q_dir = '{7};
    q_mag = '{100};
    drive_samples(1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midscan_rst_ready", int'(din_ready), 1);
    check("midscan_rst_valid", int'(peak_valid), 0);
    check("midscan_rst_busy", int'(busy), 0);

    foreach (vecs[v]) begin
      q_dir.delete();
      q_mag.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        q_dir.push_back(vecs[v].d[i]);
        q_mag.push_back(vecs[v].m[i]);
      end
      drive_samples(1'b0);
      finish_window($sformatf("vec%0d", v), vecs[v].exp_bin, vecs[v].exp_val, 0);
    end

    // Saturation: 300 x 255 on bin 31 must clamp, not wrap.
    q_dir.delete();
    q_mag.delete();
    for (int i = 0; i < 300; i++) begin
      q_dir.push_back(31);
      q_mag.push_back(255);
    end
    drive_samples(1'b0);
    finish_window("saturate", 31, 16'hFFFF, 0);

    // Backpressure, then a tiny window proves the clear.
    q_dir = '{12, 12, 5};
    q_mag = '{200, 100, 77};
    drive_samples(1'b0);
    finish_window("backpressure", 12, 300, 10);
    q_dir = '{0};
    q_mag = '{1};
    drive_samples(1'b0);
    finish_window("after_clear", 0, 1, 0);

    // All-zero window over varied directions.
    q_dir.delete();
    q_mag.delete();
    for (int i = 0; i < 16; i++) begin
      q_dir.push_back((i * 7 + 3) % 32);
      q_mag.push_back(0);
    end
    drive_samples(1'b0);
    finish_window("all_zero", 0, 0, 0);

    // Random windows against the model; narrow dir/mag ranges provoke ties.
    for (int w = 0; w < 24; w++) begin
      int n;
      int dmax;
      int mmax;
      q_dir.delete();
      q_mag.delete();
      n    = $urandom_range(1, 40);
      dmax = (w % 3 == 0) ? 3 : 31;
      mmax = (w % 4 == 1) ? 2 : 255;
      for (int i = 0; i < n; i++) begin
        q_dir.push_back($urandom_range(0, dmax));
        q_mag.push_back($urandom_range(0, mmax));
      end
      run_queue($sformatf("rand%0d", w), 1'b1, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
